// File: rtl/piece_collision_checker.sv
// piece_collision_checker
//
// Decides whether the active tetrimino, after an optional one-step move,
// would leave the playfield or land on a locked cell. Four cells are
// examined one per clock after a check request; the result is sticky.
//
// Handshake: a request is accepted on any clock edge where check=1 and no
// evaluation is in progress (IDLE or DONE). Exactly four edges later done
// rises together with the final out; both then hold until the next
// accepted check (which drops done after one edge) or reset. check seen
// while an evaluation is running is dropped, not queued.
//
// Configuration macro: CC_OPEN_TOP_EN
//   defined   - targets above the top row (ty >= ROWS but not a wrapped
//               underflow) are treated as free, allowing off-screen spawns.
//   undefined - any ty >= ROWS is a hit.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   matrixIn     locked cells, matrixIn[y][x]=1 means occupied (read live)
//   inX, inY     coordinates of the four piece cells
//   left/right/down/load  move selection, priority load>down>left>right
//   check        start an evaluation
//   out          1 = collision or out of bounds (registered)
//   done         result valid (registered)
//   dbg_state_o  current FSM state, for observation only
module piece_collision_checker #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int XW   = 3,
    parameter int YW   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ROWS-1:0][COLS-1:0]  matrixIn,
    input  logic [3:0][XW:0]           inX,
    input  logic [3:0][YW:0]           inY,
    input  logic                       left,
    input  logic                       right,
    input  logic                       down,
    input  logic                       load,
    input  logic                       check,
    output logic                       out,
    output logic                       done,
    output logic [1:0]                 dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW:0] COLS_W  = COLS[XW:0];
    localparam logic [YW:0] ROWS_W  = ROWS[YW:0];
    // Largest out-of-range y that is still "above the top" rather than a
    // wrapped underflow from row 0.
    localparam logic [YW:0] TOP_MAX = {(YW+1){1'b1}} - ROWS_W;

    state_t           state_q, state_d;
    logic [1:0]       idx_q,   idx_d;
    logic [3:0][XW:0] x_q,     x_d;
    logic [3:0][YW:0] y_q,     y_d;
    logic [XW:0]      dx_q,    dx_d;
    logic [YW:0]      dy_q,    dy_d;
    logic             out_q,   out_d;
    logic             done_q,  done_d;

    logic [XW:0] tx;
    logic [YW:0] ty;
    logic        x_oob;
    logic        y_oob;
    logic        y_open;
    logic        cell_occ;
    logic        hit;

    // Target of the cell currently addressed; offsets are stored in two's
    // complement so -1 is all-ones and 0-1 wraps out of range naturally.
    assign tx    = x_q[idx_q] + dx_q;
    assign ty    = y_q[idx_q] + dy_q;
    assign x_oob = (tx >= COLS_W);
    assign y_oob = (ty >= ROWS_W);

`ifdef CC_OPEN_TOP_EN
    assign y_open = y_oob && (ty <= TOP_MAX);
`else
    assign y_open = 1'b0;
`endif

    // Only address the matrix for in-range targets.
    always_comb begin
        cell_occ = 1'b0;
        if (!x_oob && !y_oob) begin
            cell_occ = matrixIn[ty[YW-1:0]][tx[XW-1:0]];
        end
    end

    assign hit = x_oob || (y_oob && !y_open) || cell_occ;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        out_d   = out_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (check) begin
                    x_d     = inX;
                    y_d     = inY;
                    idx_d   = 2'd0;
                    out_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = EVAL;
                    dx_d    = '0;
                    dy_d    = '0;
                    if (load) begin
                        dx_d = '0;
                        dy_d = '0;
                    end else if (down) begin
                        dy_d = '1;
                    end else if (left) begin
                        dx_d = '1;
                    end else if (right) begin
                        dx_d = {{XW{1'b0}}, 1'b1};
                    end
                end
            end
            EVAL: begin
                if (hit) begin
                    out_d = 1'b1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                done_d  = 1'b0;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out         = out_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piece_collision_checker.sv
module tb_piece_collision_checker;

  logic             clk;
  logic             reset;
  logic [7:0][7:0]  matrixIn;
  logic [3:0][3:0]  inX;
  logic [3:0][3:0]  inY;
  logic             left;
  logic             right;
  logic             down;
  logic             load;
  logic             check;
  logic             out;
  logic             done;
  logic [1:0]       dbg_state;

  int vectors;
  int miscompares;

  piece_collision_checker #(
    .ROWS(8), .COLS(8), .XW(3), .YW(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .matrixIn   (matrixIn),
    .inX        (inX),
    .inY        (inY),
    .left       (left),
    .right      (right),
    .down       (down),
    .load       (load),
    .check      (check),
    .out        (out),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the prioritised move to each cell with 4-bit wrap,
  // then test bounds and occupancy.
  function automatic logic model(input logic [7:0][7:0] mat,
                                 input logic [3:0][3:0] xs,
                                 input logic [3:0][3:0] ys,
                                 input logic l, input logic r,
                                 input logic d, input logic ld);
    int dx, dy, tx, ty;
    logic res;
    dx = 0;
    dy = 0;
    if (ld) begin
      dx = 0; dy = 0;
    end else if (d) begin
      dy = -1;
    end else if (l) begin
      dx = -1;
    end else if (r) begin
      dx = 1;
    end
    res = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tx = (int'(xs[k]) + dx + 16) % 16;
      ty = (int'(ys[k]) + dy + 16) % 16;
      if (tx >= 8) res = 1'b1;
      else if (ty >= 8) begin
`ifdef CC_OPEN_TOP_EN
        if (ty > 16 - 1 - 8) res = 1'b1;
`else
        res = 1'b1;
`endif
      end else if (mat[ty][tx]) res = 1'b1;
    end
    return res;
  endfunction

  task automatic drive_idle_moves();
    check = 1'b0;
    left  = 1'($urandom_range(0, 1));
    right = 1'($urandom_range(0, 1));
    down  = 1'($urandom_range(0, 1));
    load  = 1'($urandom_range(0, 1));
    inX   = 16'($urandom);
    inY   = 16'($urandom);
  endtask

  // One full request: check at E0, done expected exactly after E4.
  task automatic run(input string tag,
                     input logic [7:0][7:0] mat,
                     input logic [3:0][3:0] xs,
                     input logic [3:0][3:0] ys,
                     input logic l, input logic r,
                     input logic d, input logic ld);
    logic exp_out;
    exp_out  = model(mat, xs, ys, l, r, d, ld);
    matrixIn = mat;
    inX      = xs;
    inY      = ys;
    left     = l;
    right    = r;
    down     = d;
    load     = ld;
    check    = 1'b1;
    tick();
    drive_idle_moves();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk({tag, "_done_early"}, 32'(done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
  endtask

  logic [7:0][7:0] empty_m;
  logic [7:0][7:0] mat_r;

  initial begin
    vectors     = 0;
    miscompares = 0;
    empty_m     = '0;
    reset       = 1'b0;
    matrixIn    = '0;
    inX         = '0;
    inY         = '0;
    left        = 1'b0;
    right       = 1'b0;
    down        = 1'b0;
    load        = 1'b0;
    check       = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_out", 32'(out), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // directed cases; coordinate lists are cell3..cell0 (packed order)
    run("o_down", empty_m, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd6, 4'd6, 4'd7, 4'd7}, 0, 0, 1, 0);
    run("o_floor", empty_m, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd0, 4'd0, 4'd1, 4'd1}, 0, 0, 1, 0);
    run("o_load", empty_m, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd0, 4'd0, 4'd1, 4'd1}, 0, 0, 1, 1);
    run("x0_left", empty_m, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd2, 4'd3, 4'd4}, 1, 0, 0, 0);
    run("x7_right", empty_m, {4'd7, 4'd7, 4'd7, 4'd7}, {4'd1, 4'd2, 4'd3, 4'd4}, 0, 1, 0, 0);
    run("x7_lr", empty_m, {4'd7, 4'd7, 4'd7, 4'd7}, {4'd1, 4'd2, 4'd3, 4'd4}, 1, 1, 0, 0);
    run("x0_lr", empty_m, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd1, 4'd2, 4'd3, 4'd4}, 1, 1, 0, 0);
    mat_r = '0;
    mat_r[5][4] = 1'b1;
    run("lock_down", mat_r, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd6, 4'd6, 4'd7, 4'd7}, 0, 0, 1, 0);
    run("lock_right", mat_r, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd6, 4'd6, 4'd7, 4'd7}, 0, 1, 0, 0);
    run("lock_self", mat_r, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd5, 4'd6, 4'd7, 4'd7}, 0, 0, 0, 1);

    // check during EVAL is ignored
    matrixIn = '0;
    inX = {4'd4, 4'd3, 4'd4, 4'd3};
    inY = {4'd3, 4'd3, 4'd4, 4'd4};
    load = 1'b1; left = 1'b0; right = 1'b0; down = 1'b0;
    check = 1'b1;
    tick();
    check = 1'b0; load = 1'b0;
    tick();
    inX = '0; left = 1'b1; check = 1'b1;
    tick();
    check = 1'b0; left = 1'b0;
    tick();
    chk("pulse_done_e3", 32'(done), 32'd0);
    tick();
    chk("pulse_done_e4", 32'(done), 32'd1);
    chk("pulse_out", 32'(out), 32'd0);

    // check in DONE restarts; done drops for four clocks
    inX = '0;
    inY = {4'd1, 4'd2, 4'd3, 4'd4};
    left = 1'b1;
    check = 1'b1;
    tick();
    drive_idle_moves();
    chk("restart_done_drop", 32'(done), 32'd0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("restart_done_low", 32'(done), 32'd0);
    end
    tick();
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_out", 32'(out), 32'd1);

    // sticky out visible mid-evaluation, then reset aborts at once
    inX = {4'd3, 4'd3, 4'd3, 4'd0};
    inY = {4'd2, 4'd2, 4'd2, 4'd2};
    left = 1'b1; right = 1'b0; down = 1'b0; load = 1'b0;
    check = 1'b1;
    tick();
    check = 1'b0; left = 1'b0;
    tick();
    chk("mid_out_sticky", 32'(out), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_stays_idle", 32'(done), 32'd0);
    end
    run("post_abort", empty_m, {4'd4, 4'd3, 4'd4, 4'd3}, {4'd6, 4'd6, 4'd7, 4'd7}, 0, 0, 1, 0);

    // randomized requests against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [3:0][3:0] xs;
      logic [3:0][3:0] ys;
      for (int r = 0; r < 8; r++) begin
        mat_r[r] = 8'($urandom & $urandom & $urandom);
      end
      for (int k = 0; k < 4; k++) begin
        xs[k] = 4'($urandom_range(0, 8));
        ys[k] = 4'($urandom_range(0, 8));
      end
      run("rand", mat_r, xs, ys,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
